// File: rtl/scalar_mult_ctrl.sv
// ============================================================================
// Module   : scalar_mult_ctrl
// Purpose  : MSB-first double-and-add sequencer driving one point-add unit.
//            Define SCALAR_MULT_CONST_TIME_EN for the constant-time schedule.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scalar_mult_ctrl (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [254:0] i_k,
    input  logic [254:0] i_px,
    input  logic [254:0] i_py,
    input  logic [254:0] i_pz,
    input  logic [254:0] i_pt,
    output logic         o_busy,
    output logic         o_done,
    output logic [254:0] o_qx,
    output logic [254:0] o_qy,
    output logic [254:0] o_qz,
    output logic [254:0] o_qt,
    output logic         o_pa_start,
    output logic         o_pa_doubling,
    output logic         o_pa_initial,
    output logic [254:0] o_pa_x1,
    output logic [254:0] o_pa_y1,
    output logic [254:0] o_pa_z1,
    output logic [254:0] o_pa_t1,
    output logic [254:0] o_pa_x2,
    output logic [254:0] o_pa_y2,
    output logic [254:0] o_pa_z2,
    output logic [254:0] o_pa_t2,
    input  logic [254:0] i_pa_x3,
    input  logic [254:0] i_pa_y3,
    input  logic [254:0] i_pa_z3,
    input  logic [254:0] i_pa_t3,
    input  logic         i_pa_finished
);

    typedef struct packed {
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] z;
        logic [254:0] t;
    } point_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_DBL_REQ  = 3'd2,
        S_DBL_WAIT = 3'd3,
        S_ADD_REQ  = 3'd4,
        S_ADD_WAIT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam point_t C_IDENTITY = '{x: 255'd0, y: 255'd1, z: 255'd1, t: 255'd0};

    state_t       state_q, state_d;
    logic [254:0] k_q, k_d;
    point_t       p_q, p_d;
    point_t       acc_q, acc_d;
    point_t       q_q, q_d;
    logic [7:0]   idx_q, idx_d;
    logic         w_bit;
    logic         w_step;
    point_t       w_res;

    assign w_bit = k_q[idx_q];
    assign w_res = '{x: i_pa_x3, y: i_pa_y3, z: i_pa_z3, t: i_pa_t3};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        acc_d   = acc_q;
        q_d     = q_q;
        idx_d   = idx_q;
        w_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_d   = i_k;
                    p_d   = '{x: i_px, y: i_py, z: i_pz, t: i_pt};
                    idx_d = 8'd254;
`ifdef SCALAR_MULT_CONST_TIME_EN
                    acc_d   = C_IDENTITY;
                    state_d = S_DBL_REQ;
`else
                    state_d = S_SCAN;
`endif
                end
            end
            S_SCAN: begin
                if (w_bit) begin
                    acc_d = p_q;
                    if (idx_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - 8'd1;
                        state_d = S_DBL_REQ;
                    end
                end else if (idx_q == 8'd0) begin
                    acc_d   = C_IDENTITY;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 8'd1;
                end
            end
            S_DBL_REQ: state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (i_pa_finished) begin
                    acc_d = w_res;
`ifdef SCALAR_MULT_CONST_TIME_EN
                    state_d = S_ADD_REQ;
`else
                    if (w_bit) begin
                        state_d = S_ADD_REQ;
                    end else begin
                        w_step = 1'b1;
                    end
`endif
                end
            end
            S_ADD_REQ: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (i_pa_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    // Dummy add for a 0 bit keeps timing flat; its result is dropped.
                    if (w_bit) begin
                        acc_d = w_res;
                    end
`else
                    acc_d = w_res;
`endif
                    w_step = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_step) begin
            if (idx_q == 8'd0) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q - 8'd1;
                state_d = S_DBL_REQ;
            end
        end

        // Result register loads on entry to DONE so it is valid with o_done.
        if (state_d == S_DONE && state_q != S_DONE) begin
            q_d = acc_d;
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_pa_start    = (state_q == S_DBL_REQ) || (state_q == S_ADD_REQ);
    assign o_pa_doubling = (state_q == S_DBL_REQ) || (state_q == S_DBL_WAIT);
    assign o_pa_initial  = 1'b0;

    assign o_qx = q_q.x;
    assign o_qy = q_q.y;
    assign o_qz = q_q.z;
    assign o_qt = q_q.t;

    assign o_pa_x1 = acc_q.x;
    assign o_pa_y1 = acc_q.y;
    assign o_pa_z1 = acc_q.z;
    assign o_pa_t1 = acc_q.t;
    assign o_pa_x2 = p_q.x;
    assign o_pa_y2 = p_q.y;
    assign o_pa_z2 = p_q.z;
    assign o_pa_t2 = p_q.t;

endmodule

`default_nettype wire

// File: tb/tb_scalar_mult_ctrl.sv
// ============================================================================
// Module   : tb_scalar_mult_ctrl
// Purpose  : Directed bench for scalar_mult_ctrl with a latency-10 point-add
//            model. Points encode a group element m as (m, 1+3m, 1+5m, 7m)
//            mod 2^255, so double/add are exact and k*P has a closed form.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scalar_mult_ctrl;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [254:0] i_k = '0;
    logic [254:0] i_px = '0, i_py = '0, i_pz = '0, i_pt = '0;
    logic         o_busy, o_done, o_pa_start, o_pa_doubling, o_pa_initial;
    logic [254:0] o_qx, o_qy, o_qz, o_qt;
    logic [254:0] o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1;
    logic [254:0] o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2;
    logic [254:0] pa_x3 = '0, pa_y3 = '0, pa_z3 = '0, pa_t3 = '0;
    logic         pa_fin = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [254:0] b;
    bit           seq_q[$];
    bit           pending = 1'b0;
    bit           prev_start = 1'b0;
    int           cnt = 0;
    logic [1019:0] lat_ops;

    scalar_mult_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_k(i_k),
        .i_px(i_px), .i_py(i_py), .i_pz(i_pz), .i_pt(i_pt),
        .o_busy(o_busy), .o_done(o_done),
        .o_qx(o_qx), .o_qy(o_qy), .o_qz(o_qz), .o_qt(o_qt),
        .o_pa_start(o_pa_start), .o_pa_doubling(o_pa_doubling), .o_pa_initial(o_pa_initial),
        .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1), .o_pa_t1(o_pa_t1),
        .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2), .o_pa_t2(o_pa_t2),
        .i_pa_x3(pa_x3), .i_pa_y3(pa_y3), .i_pa_z3(pa_z3), .i_pa_t3(pa_t3),
        .i_pa_finished(pa_fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [254:0] m);
        check({tag, "_x"}, o_qx, m);
        check({tag, "_y"}, o_qy, 255'd1 + 255'd3 * m);
        check({tag, "_z"}, o_qz, 255'd1 + 255'd5 * m);
        check({tag, "_t"}, o_qt, 255'd7 * m);
    endtask

    // Point-add unit model: samples a request, answers LAT cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending    = 1'b0;
            pa_fin     = 1'b0;
            cnt        = 0;
            prev_start = 1'b0;
        end else begin
            pa_fin = 1'b0;
            if (o_pa_start) begin
                check("pa_start_gap", 255'(prev_start), 255'd0);
                check("one_outstanding", 255'(pending), 255'd0);
                pending = 1'b1;
                cnt     = LAT;
                lat_ops = {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1};
                seq_q.push_back(o_pa_doubling);
                if (o_pa_doubling) begin
                    pa_x3 = o_pa_x1 << 1;
                    pa_y3 = (o_pa_y1 << 1) - 255'd1;
                    pa_z3 = (o_pa_z1 << 1) - 255'd1;
                    pa_t3 = o_pa_t1 << 1;
                end else begin
                    pa_x3 = o_pa_x1 + o_pa_x2;
                    pa_y3 = o_pa_y1 + o_pa_y2 - 255'd1;
                    pa_z3 = o_pa_z1 + o_pa_z2 - 255'd1;
                    pa_t3 = o_pa_t1 + o_pa_t2;
                end
            end else if (pending) begin
                check("op_stable", 255'({o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1} != lat_ops), 255'd0);
                cnt--;
                if (cnt == 0) begin
                    pa_fin  = 1'b1;
                    pending = 1'b0;
                end
            end
            prev_start = o_pa_start;
        end
    end

    task automatic run_op(input logic [254:0] kk, input bit inject, output int cyc);
        int busy_bad;
        bit tmo;
        @(negedge clk);
        i_k = kk;
        i_start = 1'b1;
        seq_q.delete();
        cyc = 1;
        busy_bad = 0;
        tmo = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) i_start = 1'b0;
            if (inject && cyc == 20) begin
                i_start = 1'b1;
                i_k = ~kk;
                i_px = ~b;
            end
            if (inject && cyc == 21) begin
                i_start = 1'b0;
                i_px = b;
            end
            if (!o_busy) busy_bad++;
            if (o_done) break;
            if (cyc > 20000) begin
                tmo = 1'b1;
                break;
            end
        end
        check("timeout", 255'(tmo), 255'd0);
        check("busy_during_run", 255'(busy_bad), 255'd0);
    endtask

    initial begin
        int c0, c1, c2, c5, cbig, c3, w;
        logic [254:0] kbig;
        b = 255'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6979;
        kbig = 255'd1 << 254;
        i_px = b;
        i_py = 255'd1 + 255'd3 * b;
        i_pz = 255'd1 + 255'd5 * b;
        i_pt = 255'd7 * b;

        #1;
        check("rst_busy", 255'(o_busy), 255'd0);
        check("rst_done", 255'(o_done), 255'd0);
        check("rst_pa_start", 255'(o_pa_start), 255'd0);
        check("rst_pa_dbl", 255'(o_pa_doubling), 255'd0);
        check("rst_pa_init", 255'(o_pa_initial), 255'd0);
        check("rst_qy", o_qy, 255'd0);
        check("rst_pa_y1", o_pa_y1, 255'd0);
        check("rst_pa_x2", o_pa_x2, 255'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(255'd0, 1'b0, c0);
        check_q("k0", 255'd0);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("k0_reqs", 255'(seq_q.size()), 255'd510);
`else
        check("k0_reqs", 255'(seq_q.size()), 255'd0);
        check("k0_cycles", 255'(c0), 255'd257);
`endif

        run_op(255'd1, 1'b0, c1);
        check_q("k1", b);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("k1_reqs", 255'(seq_q.size()), 255'd510);
        check("k1_cycles_flat", 255'(c1), 255'(c0));
`else
        check("k1_reqs", 255'(seq_q.size()), 255'd0);
        check("k1_cycles", 255'(c1), 255'd257);
`endif

        run_op(255'd2, 1'b0, c2);
        check_q("k2", b << 1);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("k2_reqs", 255'(seq_q.size()), 255'd510);
`else
        check("k2_reqs", 255'(seq_q.size()), 255'd1);
        check("k2_seq0", 255'(seq_q[0]), 255'd1);
`endif

        run_op(255'd5, 1'b1, c5);
        check_q("k5", 255'd5 * b);
        @(negedge clk);
        check("k5_done_pulse", 255'(o_done), 255'd0);
        check("k5_busy_after", 255'(o_busy), 255'd0);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("k5_reqs", 255'(seq_q.size()), 255'd510);
        check("k5_seq0", 255'(seq_q[0]), 255'd1);
        check("k5_seq1", 255'(seq_q[1]), 255'd0);
        check("k5_seq2", 255'(seq_q[2]), 255'd1);
        check("k5_cycles_flat", 255'(c5), 255'(c0));
`else
        check("k5_reqs", 255'(seq_q.size()), 255'd3);
        check("k5_seq0", 255'(seq_q[0]), 255'd1);
        check("k5_seq1", 255'(seq_q[1]), 255'd1);
        check("k5_seq2", 255'(seq_q[2]), 255'd0);
`endif

        run_op(kbig, 1'b0, cbig);
        check_q("kmsb", kbig * b);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("kmsb_reqs", 255'(seq_q.size()), 255'd510);
        check("kmsb_cycles_flat", 255'(cbig), 255'(c5));
`else
        check("kmsb_reqs", 255'(seq_q.size()), 255'd254);
`endif

        // Abandon a k=5 run while a doubling is outstanding.
        @(negedge clk);
        i_k = 255'd5;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        w = 0;
        while (!(pending && o_pa_doubling && !o_pa_start) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("wait_dbl_wait", 255'(w < 2000), 255'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 255'(o_busy), 255'd0);
        check("mid_rst_pa_dbl", 255'(o_pa_doubling), 255'd0);
        check("mid_rst_qx", o_qx, 255'd0);
        check("mid_rst_pa_x1", o_pa_x1, 255'd0);
        check("mid_rst_pa_t2", o_pa_t2, 255'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(255'd3, 1'b0, c3);
        check_q("k3", 255'd3 * b);
`ifdef SCALAR_MULT_CONST_TIME_EN
        check("k3_reqs", 255'(seq_q.size()), 255'd510);
`else
        check("k3_reqs", 255'(seq_q.size()), 255'd2);
        check("k3_seq1", 255'(seq_q[1]), 255'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
